bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
- Responder side of the BR/BA bus-mastering handshake used by the BrainForge8 DMA and other bus masters.
- Arbitrates up to NREQ requesters against the CPU, the default owner.
- Asks the CPU to release the bus and waits for it to go idle. Then grants exactly one requester, holds the grant while its BR stays high, and revokes overlong holds.
- Sits between the CPU core and the shared D/A/RW bus; its BA outputs drive each master's BA input.

Parameters:
NREQ, 2, number of external requesters; legal range 1..4
MAX_HOLD, 16'hFFFF, maximum consecutive granted cycles before forced revoke

Ports:
CLK  input  1  system clock; all state changes on rising edge
RST  input  1  asynchronous, active-high reset
BR  input  NREQ  bus request per requester; bit k = requester k
BA  output  NREQ  bus acknowledge per requester; at most one bit high (one-hot or zero)
CPU_HALT  output  1  asks the CPU to finish its current cycle and release the bus
CPU_IDLE  input  1  CPU has released the bus (tri-stated) while CPU_HALT is high
OWNER  output  3  current bus owner: 0 = CPU, k+1 = requester k
TRIG_BUS_VIOL  output  1  one-cycle pulse when a grant is force-revoked at MAX_HOLD

Behaviour:
- Reset values (async on RST high):
  - BA=0, CPU_HALT=0, OWNER=0, TRIG_BUS_VIOL=0
  - state=S_CPU, mask=0, hold=0, last=NREQ-1 (so requester 0 wins first)
- Eligible set: elig = BR & ~mask.
- mask[k] is set on forced revoke of k. It clears on any edge where BR[k]=0, in any state. If set and clear coincide, clear wins only when BR[k]=0.
- Winner selection: round-robin, searching from (last+1) mod NREQ upward with wrap. The first eligible index wins and last<=winner.
- TRIG_BUS_VIOL defaults to 0 every cycle and is set only as stated below.
- States:
  - S_CPU: OWNER=0, BA=0. If elig!=0: CPU_HALT<=1, go S_HALT.
  - S_HALT:
    - If elig==0: CPU_HALT<=0, go S_CPU (request withdrawn).
    - Else if CPU_IDLE: BA[w]<=1, OWNER<=w+1, hold<=0, go S_GRANT.
    - Else wait; there is no timeout.
  - S_GRANT (BA[w] held high, CPU_HALT held high):
    - If BR[w]==0: BA<=0, go S_RELEASE.
    - Else if hold==MAX_HOLD: BA<=0, mask[w]<=1, TRIG_BUS_VIOL<=1, go S_RELEASE.
    - Else hold<=hold+1. hold is 16-bit and saturates at MAX_HOLD; it never wraps.
  - S_RELEASE: one dead (turnaround) cycle with BA=0 and OWNER=0.
    - If elig!=0: select winner, BA[w]<=1, OWNER<=w+1, hold<=0, go S_GRANT. CPU_HALT stays high, so no re-handshake is needed.
    - Else: CPU_HALT<=0, go S_CPU.
  - Illegal state: same as reset values except mask is kept; go S_CPU.
- Latency: BR rising sampled at edge n sets CPU_HALT after edge n. With CPU_IDLE already high, BA rises after edge n+1. So the minimum BR-to-BA latency is 2 cycles.
- BR drop: BA falls after the edge that samples BR low, which is 1 cycle.
- Back-to-back masters: one S_RELEASE cycle separates consecutive grants.
- BA never rises while CPU_IDLE=0 in S_HALT.
- A requester whose BR drops in S_HALT is not granted. Selection uses elig at the granting edge.
- Reset mid-grant: BA drops immediately (async) and CPU_HALT drops.

Optional Feature:
- ARB_FIXED_PRIO_EN defined: fixed priority; the lowest eligible index always wins and the last register is unused.
- Undefined (default): round-robin as above.

Test Plan:
- Single request, fast CPU:
  - Stimulus: CPU_IDLE=1, BR=01 at cycle 0, held 5 cycles, then dropped.
  - Response: CPU_HALT=1 from cycle 1; BA=01 and OWNER=1 from cycle 2; BA=00 the cycle after BR drops; then one S_RELEASE cycle; CPU_HALT=0 after that.
- Slow CPU:
  - Stimulus: BR=01, CPU_IDLE low for 10 cycles.
  - Response: BA stays 00 throughout; BA=01 one cycle after CPU_IDLE rises.
  - Variant: BR withdrawn before CPU_IDLE rises gives CPU_HALT=0 and no BA pulse.
- Round-robin contention:
  - Stimulus: BR=11 continuously, each master drops BR for 1 cycle after 3 granted cycles.
  - Response: grant order 0,1,0,1; exactly one S_RELEASE cycle between grants; CPU_HALT stays high throughout.
  - With ARB_FIXED_PRIO_EN: order 0,0,0.
- Forced revoke:
  - Stimulus: MAX_HOLD=8, BR[0] held high indefinitely, BR[1]=0.
  - Response: BA[0] high for 9 cycles then low; TRIG_BUS_VIOL pulses for 1 cycle; no re-grant to 0 until BR[0] goes low then high; CPU_HALT returns to 0.
- Async reset:
  - Stimulus: assert RST while in S_GRANT.
  - Response: BA=00, CPU_HALT=0, OWNER=0 without waiting for a clock edge; after release, the first grant goes to requester 0.
- Invariant check over random BR/CPU_IDLE traffic:
  - BA is always one-hot or zero.
  - BA is never nonzero unless CPU_HALT=1.
  - OWNER always matches BA.

Source files
------------

// File: rtl/bus_arbiter.sv
// ----------------------------------------------------------------------------
// bus_arbiter
//   Responder side of the BR/BA bus-mastering handshake. The CPU owns the
//   shared bus by default. When an external master raises BR, the arbiter
//   raises CPU_HALT and waits for CPU_IDLE. It then grants exactly one master
//   (BA), keeps the grant while that master's BR stays high, and force-revokes
//   a grant that has been held for MAX_HOLD cycles. A single dead cycle
//   (S_RELEASE) separates consecutive grants.
//
// Parameters
//   NREQ      number of external requesters (1..4)
//   MAX_HOLD  granted cycles allowed before a forced revoke
//
// Ports
//   CLK            system clock, rising edge
//   RST            asynchronous, active-high reset
//   BR[NREQ]       bus request, bit k = requester k
//   BA[NREQ]       bus acknowledge, one-hot or zero
//   CPU_HALT       asks the CPU to release the bus
//   CPU_IDLE       CPU has released the bus
//   OWNER[3]       0 = CPU, k+1 = requester k
//   TRIG_BUS_VIOL  one-cycle pulse on a forced revoke
//
// Build option
//   ARB_FIXED_PRIO_EN  when defined, the lowest eligible index always wins;
//                      otherwise selection is round-robin after the last winner.
// ----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int          NREQ     = 2,
  parameter logic [15:0] MAX_HOLD = 16'hFFFF
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] BR,
  output logic [NREQ-1:0] BA,
  output logic            CPU_HALT,
  input  logic            CPU_IDLE,
  output logic [2:0]      OWNER,
  output logic            TRIG_BUS_VIOL
);

  typedef enum logic [1:0] {
    S_CPU     = 2'd0,
    S_HALT    = 2'd1,
    S_GRANT   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  // Starting at NREQ-1 makes requester 0 the first round-robin winner.
  localparam logic [1:0] LAST_INIT = 2'(NREQ - 1);

  state_t          state_r;
  logic [NREQ-1:0] ba_r;
  logic            halt_r;
  logic [2:0]      owner_r;
  logic            trig_r;
  logic [NREQ-1:0] mask_r;
  logic [15:0]     hold_r;
  logic [1:0]      last_r;
  logic [1:0]      grant_idx_r;

  logic [NREQ-1:0] elig_s;
  logic [3:0]      elig_pad_s;
  logic [3:0]      br_pad_s;
  logic            win_vld_s;
  logic [1:0]      win_idx_s;
  logic [1:0]      rr_idx_s;
  logic [NREQ-1:0] win_vec_s;

  assign elig_s = BR & ~mask_r;

  // Pad request vectors to four bits so two-bit indices are always in range.
  always_comb begin
    elig_pad_s = 4'b0000;
    br_pad_s   = 4'b0000;
    elig_pad_s[NREQ-1:0] = elig_s;
    br_pad_s[NREQ-1:0]   = BR;
  end

  // Winner selection; later loop iterations have higher priority.
  always_comb begin
    win_vld_s = 1'b0;
    win_idx_s = 2'd0;
    rr_idx_s  = 2'd0;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (elig_pad_s[i]) begin
        win_vld_s = 1'b1;
        win_idx_s = 2'(i);
      end else begin
        win_vld_s = win_vld_s;
      end
    end
`else
    // Offset 1 after the last winner is searched last, so it wins.
    for (int i = NREQ; i >= 1; i--) begin
      rr_idx_s = 2'((int'(last_r) + i) % NREQ);
      if (elig_pad_s[rr_idx_s]) begin
        win_vld_s = 1'b1;
        win_idx_s = rr_idx_s;
      end else begin
        win_vld_s = win_vld_s;
      end
    end
`endif
  end

  // One-hot grant vector for the selected winner.
  always_comb begin
    win_vec_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx_s == 2'(i)) begin
        win_vec_s[i] = 1'b1;
      end else begin
        win_vec_s[i] = 1'b0;
      end
    end
  end

  // Arbitration FSM with registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r     <= S_CPU;
      ba_r        <= '0;
      halt_r      <= 1'b0;
      owner_r     <= 3'd0;
      trig_r      <= 1'b0;
      mask_r      <= '0;
      hold_r      <= 16'd0;
      last_r      <= LAST_INIT;
      grant_idx_r <= 2'd0;
    end else begin
      trig_r <= 1'b0;
      // A requester is unmasked as soon as it lets BR go low.
      mask_r <= mask_r & BR;
      case (state_r)
        S_CPU: begin
          ba_r    <= '0;
          owner_r <= 3'd0;
          if (elig_s != '0) begin
            halt_r  <= 1'b1;
            state_r <= S_HALT;
          end
        end
        S_HALT: begin
          if (!win_vld_s) begin
            halt_r  <= 1'b0;
            state_r <= S_CPU;
          end else if (CPU_IDLE) begin
            ba_r        <= win_vec_s;
            owner_r     <= {1'b0, win_idx_s} + 3'd1;
            hold_r      <= 16'd0;
            last_r      <= win_idx_s;
            grant_idx_r <= win_idx_s;
            state_r     <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (!br_pad_s[grant_idx_r]) begin
            ba_r    <= '0;
            owner_r <= 3'd0;
            state_r <= S_RELEASE;
          end else if (hold_r == MAX_HOLD) begin
            ba_r    <= '0;
            owner_r <= 3'd0;
            // ba_r is the one-hot of the current holder, whose BR is high here.
            mask_r  <= (mask_r | ba_r) & BR;
            trig_r  <= 1'b1;
            state_r <= S_RELEASE;
          end else begin
            hold_r <= hold_r + 16'd1;
          end
        end
        S_RELEASE: begin
          // CPU_HALT is still high, so the next master is granted directly.
          if (win_vld_s) begin
            ba_r        <= win_vec_s;
            owner_r     <= {1'b0, win_idx_s} + 3'd1;
            hold_r      <= 16'd0;
            last_r      <= win_idx_s;
            grant_idx_r <= win_idx_s;
            state_r     <= S_GRANT;
          end else begin
            halt_r  <= 1'b0;
            state_r <= S_CPU;
          end
        end
        default: begin
          ba_r        <= '0;
          halt_r      <= 1'b0;
          owner_r     <= 3'd0;
          trig_r      <= 1'b0;
          hold_r      <= 16'd0;
          last_r      <= LAST_INIT;
          grant_idx_r <= 2'd0;
          state_r     <= S_CPU;
        end
      endcase
    end
  end

  assign BA            = ba_r;
  assign CPU_HALT      = halt_r;
  assign OWNER         = owner_r;
  assign TRIG_BUS_VIOL = trig_r;

endmodule
